mesh_terminal_port: RTL and testbench

Per-terminal endpoint that connects one device to one mesh router terminal. Buffers device-issued packets in a TX FIFO presented to the mesh input handshake (`pndng_i_in` / `data_out_i_in` / `popin`). Drains the mesh output handshake (`pndng` / `data_out` / `pop`) into an RX FIFO for the device. Checks each received packet's destination against the terminal's own coordinates. Sixteen instances sit around `mesh_gnrtr`, one per terminal index.

---
 rtl/mesh_terminal_port.sv | 149 ++++++++++++++
 tb/tb_mesh_terminal_port.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_terminal_port.sv
`default_nettype none
// ============================================================================
// Module   : mesh_terminal_port
// Brief    : Mesh terminal endpoint: TX FIFO to mesh input, RX FSM + FIFO from
//            mesh output, with destination (row/col) misroute counting.
// Revision : 1.0 - initial release
// ============================================================================
module mesh_terminal_port #(
  parameter int         pckg_sz    = 40,
  parameter int         fifo_depth = 4,
  parameter logic [3:0] ROW_ID     = 4'd0,
  parameter logic [3:0] COL_ID     = 4'd0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_push,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               tx_full,
  output logic               pndng_i_in,
  output logic [pckg_sz-1:0] data_out_i_in,
  input  logic               popin,
  input  logic               pndng,
  input  logic [pckg_sz-1:0] data_out,
  output logic               pop,
  input  logic               rx_pop,
  output logic               rx_pndng,
  output logic [pckg_sz-1:0] rx_data,
  output logic               tx_overflow,
  output logic [7:0]         misroute_cnt
);

  localparam int c_PTR_W = $clog2(fifo_depth);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(fifo_depth);

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_POP  = 2'd1,
    RX_WAIT = 2'd2
  } rx_state_t;

  // ---------------- TX FIFO ----------------
  logic [pckg_sz-1:0] r_tx_mem [fifo_depth];
  logic [c_PTR_W-1:0] r_tx_wr, r_tx_rd;
  logic [c_CNT_W-1:0] r_tx_cnt;
  logic               r_tx_ovf;
  logic               w_tx_wen, w_tx_ren;

  assign tx_full       = (r_tx_cnt == c_DEPTH);
  assign pndng_i_in    = (r_tx_cnt != '0);
  assign w_tx_wen      = tx_push && !tx_full;
  assign w_tx_ren      = popin && pndng_i_in;
  assign data_out_i_in = pndng_i_in ? r_tx_mem[r_tx_rd] : '0;
  assign tx_overflow   = r_tx_ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_wr  <= '0;
      r_tx_rd  <= '0;
      r_tx_cnt <= '0;
      r_tx_ovf <= 1'b0;
    end else begin
      if (w_tx_wen) r_tx_wr <= r_tx_wr + 1'b1;
      if (w_tx_ren) r_tx_rd <= r_tx_rd + 1'b1;
      case ({w_tx_wen, w_tx_ren})
        2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
        2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
        default: r_tx_cnt <= r_tx_cnt;
      endcase
      // A push against a full FIFO is lost even if the head leaves this cycle.
      if (tx_push && tx_full) r_tx_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_wen) r_tx_mem[r_tx_wr] <= tx_data;
  end

  // ---------------- RX FSM ----------------
  rx_state_t          r_state, w_state_nxt;
  logic               r_pop, w_pop_nxt;
  logic [pckg_sz-1:0] r_rx_mem [fifo_depth];
  logic [c_PTR_W-1:0] r_rx_wr, r_rx_rd;
  logic [c_CNT_W-1:0] r_rx_cnt;
  logic [7:0]         r_mis;
  logic               w_rx_full, w_rx_wen, w_rx_ren, w_misroute;

  assign w_rx_full = (r_rx_cnt == c_DEPTH);

  always_comb begin
    w_state_nxt = r_state;
    w_pop_nxt   = 1'b0;
    case (r_state)
      RX_IDLE: if (pndng && !w_rx_full) begin
        w_state_nxt = RX_POP;
        w_pop_nxt   = 1'b1;
      end
      RX_POP:  w_state_nxt = RX_WAIT;
      // One dead cycle lets the mesh retire the consumed packet from pndng.
      RX_WAIT: w_state_nxt = RX_IDLE;
      default: w_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RX_IDLE;
      r_pop   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pop   <= w_pop_nxt;
    end
  end

  assign pop = r_pop;

  // ---------------- RX FIFO ----------------
  assign w_rx_wen   = (r_state == RX_POP);
  assign w_rx_ren   = rx_pop && rx_pndng;
  assign rx_pndng   = (r_rx_cnt != '0);
  assign rx_data    = rx_pndng ? r_rx_mem[r_rx_rd] : '0;
  assign w_misroute = (data_out[pckg_sz-9 -: 4] != ROW_ID) ||
                      (data_out[pckg_sz-13 -: 4] != COL_ID);
  assign misroute_cnt = r_mis;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_wr  <= '0;
      r_rx_rd  <= '0;
      r_rx_cnt <= '0;
      r_mis    <= 8'd0;
    end else begin
      if (w_rx_wen) r_rx_wr <= r_rx_wr + 1'b1;
      if (w_rx_ren) r_rx_rd <= r_rx_rd + 1'b1;
      case ({w_rx_wen, w_rx_ren})
        2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
        2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
        default: r_rx_cnt <= r_rx_cnt;
      endcase
      if (w_rx_wen && w_misroute && (r_mis != 8'hFF)) r_mis <= r_mis + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rx_wen) r_rx_mem[r_rx_wr] <= data_out;
  end

endmodule
`default_nettype wire

// File: tb/tb_mesh_terminal_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_mesh_terminal_port
// Brief    : Randomized/directed bench for mesh_terminal_port against a
//            queue-based model of the TX FIFO, mesh source and RX path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mesh_terminal_port;

  localparam int W     = 40;
  localparam int DEPTH = 4;
  localparam int VW    = 2*W + 5;
  localparam logic [3:0] ROW = 4'd2;
  localparam logic [3:0] COL = 4'd3;

  logic         clk = 1'b0;
  logic         reset;
  logic         tx_push, popin, pndng, rx_pop;
  logic [W-1:0] tx_data, data_out;
  logic         tx_full, pndng_i_in, pop, rx_pndng, tx_overflow;
  logic [W-1:0] data_out_i_in, rx_data;
  logic [7:0]   misroute_cnt;
  logic [VW-1:0] dut_vec;

  int n_cmp = 0;
  int n_fail = 0;

  // Model: TX FIFO contents, RX FIFO contents, packets the mesh still holds.
  logic [W-1:0] txq[$], rxq[$], meshq[$];
  bit  m_ovf;
  int  m_mis;
  bit  exp_pop;
  int  last_pop, edge_n;

  always #5 clk = ~clk;

  mesh_terminal_port #(.pckg_sz(W), .fifo_depth(DEPTH), .ROW_ID(ROW), .COL_ID(COL)) dut (
    .clk(clk), .reset(reset), .tx_push(tx_push), .tx_data(tx_data), .tx_full(tx_full),
    .pndng_i_in(pndng_i_in), .data_out_i_in(data_out_i_in), .popin(popin), .pndng(pndng),
    .data_out(data_out), .pop(pop), .rx_pop(rx_pop), .rx_pndng(rx_pndng), .rx_data(rx_data),
    .tx_overflow(tx_overflow), .misroute_cnt(misroute_cnt)
  );

  assign dut_vec = {pndng_i_in, tx_full, tx_overflow, rx_pndng, pop, data_out_i_in, rx_data};

  function automatic logic [W-1:0] mk_pkt(input logic [3:0] row, input logic [3:0] col);
    logic [W-1:0] p;
    p[31:0]      = $urandom;
    p[W-1:32]    = 8'($urandom);
    p[W-9 -: 4]  = row;
    p[W-13 -: 4] = col;
    return p;
  endfunction

  function automatic void model_reset();
    txq.delete(); rxq.delete(); meshq.delete();
    m_ovf = 1'b0; m_mis = 0; exp_pop = 1'b0; last_pop = -10; edge_n = 0;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [W-1:0] th, rh;
    th = (txq.size() > 0) ? txq[0] : '0;
    rh = (rxq.size() > 0) ? rxq[0] : '0;
    return {txq.size() > 0, txq.size() == DEPTH, m_ovf, rxq.size() > 0, exp_pop, th, rh};
  endfunction

  // One clock edge: mesh drives its head packet, model follows the edge.
  task automatic step();
    logic p_push, p_popin, p_rxpop, p_cap, p_pend;
    logic [W-1:0] p_data, pkt;
    int txs, rxs;
    pndng    = (meshq.size() > 0);
    data_out = pndng ? meshq[0] : '0;
    p_push = tx_push; p_data = tx_data; p_popin = popin; p_rxpop = rx_pop;
    p_cap = exp_pop; p_pend = pndng; txs = txq.size(); rxs = rxq.size();
    @(posedge clk); #1;
    edge_n++;
    if (p_popin && txs > 0) void'(txq.pop_front());
    if (p_push) begin
      if (txs < DEPTH) txq.push_back(p_data);
      else m_ovf = 1'b1;
    end
    if (p_rxpop && rxs > 0) void'(rxq.pop_front());
    if (p_cap && meshq.size() > 0) begin
      pkt = meshq.pop_front();
      rxq.push_back(pkt);
      if ((pkt[W-9 -: 4] != ROW || pkt[W-13 -: 4] != COL) && m_mis < 255) m_mis++;
    end
    // A pop needs a waiting packet, room in RX, and three edges since the last one.
    exp_pop = p_pend && (rxs < DEPTH) && ((edge_n - last_pop) >= 3);
    if (exp_pop) last_pop = edge_n;
    tx_push = 1'b0; popin = 1'b0; rx_pop = 1'b0;
    pndng    = (meshq.size() > 0);
    data_out = pndng ? meshq[0] : '0;
  endtask

  task automatic do_reset();
    tx_push = 1'b0; popin = 1'b0; rx_pop = 1'b0; pndng = 1'b0; data_out = '0; tx_data = '0;
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1; pndng = 1'b1; data_out = mk_pkt(ROW, COL);
    tx_push = 1'b1; tx_data = {W{1'b1}}; popin = 1'b0; rx_pop = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({dut_vec, misroute_cnt} !== '0) begin
        n_fail++; $display("FAIL reset_outputs cyc%0d: got %h want 0", i, {dut_vec, misroute_cnt});
      end
      @(posedge clk); #1;
    end
    tx_push = 1'b0;
    model_reset();
    meshq.push_back(data_out);
    reset = 1'b0; #1;
    n_cmp++;
    if (pop !== 1'b0) begin n_fail++; $display("FAIL reset_release_pop: got %b want 0", pop); end
    step();
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL reset_first_edge: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_tx_single();
    logic [W-1:0] v;
    v = 40'h00_23_AAAAAA;
    do_reset();
    tx_data = v; tx_push = 1'b1; step();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (pndng_i_in !== 1'b1 || data_out_i_in !== v) begin
        n_fail++; $display("FAIL tx_single_hold cyc%0d: got %b/%h want 1/%h", i, pndng_i_in, data_out_i_in, v);
      end
      if (i == 2) popin = 1'b1;
      step();
    end
    n_cmp++;
    if (pndng_i_in !== 1'b0 || data_out_i_in !== '0) begin
      n_fail++; $display("FAIL tx_single_drain: got %b/%h want 0/0", pndng_i_in, data_out_i_in);
    end
  endtask

  task automatic test_tx_overflow();
    logic [W-1:0] pk[5];
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pk[i] = mk_pkt(4'($urandom), 4'($urandom));
      tx_data = pk[i]; tx_push = 1'b1; step();
      if (i == 3) begin
        n_cmp++;
        if (tx_full !== 1'b1 || tx_overflow !== 1'b0) begin
          n_fail++; $display("FAIL tx_full_at4: got full=%b ovf=%b want 1/0", tx_full, tx_overflow);
        end
      end
    end
    n_cmp++;
    if (tx_overflow !== 1'b1 || tx_full !== 1'b1) begin
      n_fail++; $display("FAIL tx_overflow_set: got ovf=%b full=%b want 1/1", tx_overflow, tx_full);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (data_out_i_in !== pk[i]) begin
        n_fail++; $display("FAIL tx_order%0d: got %h want %h", i, data_out_i_in, pk[i]);
      end
      popin = 1'b1; step();
    end
    n_cmp++;
    if (pndng_i_in !== 1'b0 || tx_overflow !== 1'b1) begin
      n_fail++; $display("FAIL tx_after_drain: got pend=%b ovf=%b want 0/1", pndng_i_in, tx_overflow);
    end
  endtask

  task automatic test_rx_stream();
    logic [W-1:0] pk[3];
    logic [8:0] seen;
    do_reset();
    seen = '0;
    for (int i = 0; i < 3; i++) begin pk[i] = mk_pkt(ROW, COL); meshq.push_back(pk[i]); end
    for (int i = 0; i < 9; i++) begin
      step();
      seen[i] = pop;
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL rx_stream cyc%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    n_cmp++;
    if (seen !== 9'b001001001) begin
      n_fail++; $display("FAIL rx_stream_pop_pattern: got %b want 001001001", seen);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (rx_data !== pk[i]) begin
        n_fail++; $display("FAIL rx_stream_order%0d: got %h want %h", i, rx_data, pk[i]);
      end
      rx_pop = 1'b1; step();
    end
    n_cmp++;
    if (misroute_cnt !== 8'd0 || rx_pndng !== 1'b0) begin
      n_fail++; $display("FAIL rx_stream_end: got mis=%0d pend=%b want 0/0", misroute_cnt, rx_pndng);
    end
  endtask

  task automatic test_rx_full();
    int npop;
    do_reset();
    npop = 0;
    for (int i = 0; i < 6; i++) meshq.push_back(mk_pkt(4'd1, 4'd1));
    for (int i = 0; i < 24; i++) begin
      step();
      if (pop === 1'b1) npop++;
    end
    n_cmp++;
    if (npop != 4 || misroute_cnt !== 8'd4 || rx_pndng !== 1'b1) begin
      n_fail++; $display("FAIL rx_full_stall: got pops=%0d mis=%0d pend=%b want 4/4/1", npop, misroute_cnt, rx_pndng);
    end
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL rx_full_state: got %h want %h", dut_vec, exp_vec());
    end
    rx_pop = 1'b1; step();
    n_cmp++;
    if (pop !== 1'b0) begin n_fail++; $display("FAIL rx_full_read_edge_pop: got %b want 0", pop); end
    step();
    n_cmp++;
    if (pop !== 1'b1) begin n_fail++; $display("FAIL rx_full_resume_pop: got %b want 1", pop); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, c;
    do_reset();
    a = mk_pkt(ROW, COL); b = mk_pkt(ROW, COL); c = mk_pkt(ROW, COL);
    tx_data = a; tx_push = 1'b1; step();
    tx_data = b; tx_push = 1'b1; step();
    tx_data = c; tx_push = 1'b1; popin = 1'b1; step();
    n_cmp++;
    if (pndng_i_in !== 1'b1 || tx_full !== 1'b0 || data_out_i_in !== b) begin
      n_fail++; $display("FAIL tx_simul: got pend=%b full=%b head=%h want 1/0/%h", pndng_i_in, tx_full, data_out_i_in, b);
    end
    popin = 1'b1; step();
    n_cmp++;
    if (data_out_i_in !== c) begin n_fail++; $display("FAIL tx_simul_second: got %h want %h", data_out_i_in, c); end
    popin = 1'b1; step();
    n_cmp++;
    if (pndng_i_in !== 1'b0) begin n_fail++; $display("FAIL tx_simul_empty: got %b want 0", pndng_i_in); end
    meshq.push_back(a);
    for (int i = 0; i < 10 && rxq.size() == 0; i++) step();
    meshq.push_back(c);
    for (int i = 0; i < 10 && pop !== 1'b1; i++) step();
    n_cmp++;
    if (pop !== 1'b1 || rx_data !== a) begin
      n_fail++; $display("FAIL rx_simul_pre: got pop=%b data=%h want 1/%h", pop, rx_data, a);
    end
    rx_pop = 1'b1; step();
    n_cmp++;
    if (rx_pndng !== 1'b1 || rx_data !== c) begin
      n_fail++; $display("FAIL rx_simul_count: got pend=%b data=%h want 1/%h", rx_pndng, rx_data, c);
    end
    rx_pop = 1'b1; step();
    n_cmp++;
    if (rx_pndng !== 1'b0) begin n_fail++; $display("FAIL rx_simul_drain: got %b want 0", rx_pndng); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      tx_push = 1'($urandom_range(0, 1));
      tx_data = mk_pkt(4'($urandom), 4'($urandom));
      popin   = ($urandom_range(0, 9) < 4);
      rx_pop  = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 3) == 0 && meshq.size() < 8)
        meshq.push_back(($urandom_range(0, 1) == 1) ? mk_pkt(ROW, COL) : mk_pkt(4'($urandom), 4'($urandom)));
      step();
      n_cmp++;
      if ({dut_vec, misroute_cnt} !== {exp_vec(), 8'(m_mis)}) begin
        n_fail++; $display("FAIL random cyc%0d: got %h want %h", i, {dut_vec, misroute_cnt}, {exp_vec(), 8'(m_mis)});
      end
    end
  endtask

  task automatic test_misroute_saturation();
    do_reset();
    for (int i = 0; i < 260; i++) meshq.push_back(mk_pkt(4'd9, 4'd9));
    for (int i = 0; i < 1000 && (meshq.size() > 0 || exp_pop); i++) begin
      rx_pop = 1'b1; step();
    end
    n_cmp++;
    if (misroute_cnt !== 8'd255) begin n_fail++; $display("FAIL misroute_sat: got %0d want 255", misroute_cnt); end
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL misroute_sat_state: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_midreset();
    do_reset();
    meshq.push_back(mk_pkt(ROW, COL));
    step();
    n_cmp++;
    if (pop !== 1'b1) begin n_fail++; $display("FAIL midreset_setup_pop: got %b want 1", pop); end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (pop !== 1'b0 || rx_pndng !== 1'b0) begin
      n_fail++; $display("FAIL midreset_drop: got pop=%b pend=%b want 0/0", pop, rx_pndng);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    pndng = 1'b0; data_out = '0;
    step(); step();
    n_cmp++;
    if ({dut_vec, misroute_cnt} !== '0) begin
      n_fail++; $display("FAIL midreset_after: got %h want 0", {dut_vec, misroute_cnt});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tx_single();
    test_tx_overflow();
    test_rx_stream();
    test_rx_full();
    test_back_to_back();
    test_random();
    test_misroute_saturation();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
